// File: rtl/array_divider.sv
// Fully pipelined restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor.
// Accepts one operation per cycle and produces one quotient bit per stage.
module array_divider #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2*WIDTH-1:0]   N,
    input  logic [WIDTH-1:0]     D,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]     R,
    output logic                 div_by_zero,
    output logic                 done
);

    localparam int unsigned Stages = 2 * WIDTH;

    // One restoring step. The dividend and quotient share one shift register:
    // the dividend MSB is consumed and the new quotient bit enters at the LSB.
    // The compare is WIDTH+1 bits wide; only the low WIDTH bits of the
    // difference are kept because the remainder is always below the divisor.
    function automatic logic [3*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0]   rem,
        input logic [2*WIDTH-1:0] nq,
        input logic [WIDTH-1:0]   den
    );
        logic [WIDTH:0] trial;
        logic           fit;
        trial = {rem, nq[2*WIDTH-1]};
        fit   = (trial >= {1'b0, den});
        return {(fit ? trial[WIDTH-1:0] - den : trial[WIDTH-1:0]), nq[2*WIDTH-2:0], fit};
    endfunction

    logic [Stages-1:0][WIDTH-1:0]   rem_q;
    logic [Stages-1:0][2*WIDTH-1:0] nq_q;
    logic [Stages-1:0][WIDTH-1:0]   den_q;
    logic [Stages-1:0]              zero_q;
    logic [Stages-1:0]              valid_q;

    logic [WIDTH-1:0]   fin_rem;
    logic [2*WIDTH-1:0] fin_quo;

    // Stage 0 captures the operands; each later stage and the output register
    // apply one step, giving 2*WIDTH steps in total.
    always_ff @(posedge clock) begin
        rem_q[0]  <= '0;
        nq_q[0]   <= N;
        den_q[0]  <= D;
        zero_q[0] <= (D == '0);
        for (int s = 1; s < Stages; s++) begin
            {rem_q[s], nq_q[s]} <= div_step(rem_q[s-1], nq_q[s-1], den_q[s-1]);
            den_q[s]            <= den_q[s-1];
            zero_q[s]           <= zero_q[s-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[Stages-2:0], start};
        end
    end

    assign {fin_rem, fin_quo} = div_step(rem_q[Stages-1], nq_q[Stages-1], den_q[Stages-1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= valid_q[Stages-1];
            if (valid_q[Stages-1]) begin
                Q           <= fin_quo;
                R           <= fin_rem;
                div_by_zero <= zero_q[Stages-1];
            end
        end
    end

endmodule

// File: tb/tb_array_divider.sv
// Self-checking bench for array_divider (WIDTH=8): directed cases, random streams
// against an arithmetic reference, gap timing and mid-flight reset.
module tb_array_divider;

    localparam int unsigned W   = 8;
    localparam int          Lat = 17;  // negedges from driving start to seeing done

    logic            clock;
    logic            reset_n;
    logic [2*W-1:0]  N;
    logic [W-1:0]    D;
    logic            start;
    logic [2*W-1:0]  Q;
    logic [W-1:0]    R;
    logic            div_by_zero;
    logic            done;

    int checks = 0;
    int errors = 0;

    array_divider #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .N           (N),
        .D           (D),
        .start       (start),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: plain integer division, with the defined divide-by-zero result.
    function automatic void ref_div(input logic [2*W-1:0] n, input logic [W-1:0] d,
                                    output logic [2*W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (d == '0) begin
            q = '1;
            r = n[W-1:0];
            z = 1'b1;
        end else begin
            q = n / {8'b0, d};
            r = W'(n % {8'b0, d});
            z = 1'b0;
        end
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        N       = '0;
        D       = '0;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (Q !== '0) begin errors++; $display("FAIL reset_q: got %0d expected 0", Q); end
        checks++; if (R !== '0) begin errors++; $display("FAIL reset_r: got %0d expected 0", R); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c <= Lat + 3; c++) begin
            @(negedge clock);
            checks++;
            if (done !== (c == Lat)) begin
                errors++; $display("FAIL single_done c=%0d: got %b expected %b", c, done, c == Lat);
            end
            if (c == Lat) begin
                checks++;
                if (Q !== 16'd142 || R !== 8'd6 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL single_result: got Q=%0d R=%0d z=%b expected Q=142 R=6 z=0",
                             Q, R, div_by_zero);
                end
            end
            start = (c == 0);
            N     = 16'd1000;
            D     = 8'd7;
        end
        start = 1'b0;
    endtask

    task automatic test_directed();
        logic [2*W-1:0] tn [5] = '{16'd65535, 16'd0, 16'd40000, 16'h04D2, 16'd10};
        logic [W-1:0]   td [5] = '{8'd255, 8'd5, 8'd1, 8'd0, 8'd3};
        logic [2*W-1:0] tq [5] = '{16'd257, 16'd0, 16'd40000, 16'hFFFF, 16'd3};
        logic [W-1:0]   tr [5] = '{8'd0, 8'd0, 8'd0, 8'hD2, 8'd1};
        logic           tz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int j;
        for (int c = 0; c < 5 + Lat + 2; c++) begin
            @(negedge clock);
            j = c - Lat;
            checks++;
            if (done !== (j >= 0 && j < 5)) begin
                errors++; $display("FAIL directed_done c=%0d: got %b", c, done);
            end
            if (j >= 0 && j < 5) begin
                checks++;
                if (Q !== tq[j] || R !== tr[j] || div_by_zero !== tz[j]) begin
                    errors++;
                    $display("FAIL directed_%0d: got Q=%0d R=%0d z=%b expected Q=%0d R=%0d z=%b",
                             j, Q, R, div_by_zero, tq[j], tr[j], tz[j]);
                end
            end
            start = (c < 5);
            N     = (c < 5) ? tn[c] : '0;
            D     = (c < 5) ? td[c] : '0;
        end
        start = 1'b0;
    endtask

    task automatic test_gaps();
        logic           pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2*W-1:0] pn  [5] = '{16'd100, 16'd0, 16'd0, 16'd200, 16'd300};
        logic [W-1:0]   pd  [5] = '{8'd7, 8'd0, 8'd0, 8'd9, 8'd11};
        logic [2*W-1:0] eq;
        logic [W-1:0]   er;
        logic           ez;
        int j;
        for (int c = 0; c < 5 + Lat + 2; c++) begin
            @(negedge clock);
            j = c - Lat;
            checks++;
            if (done !== (j >= 0 && j < 5 && pat[j >= 0 && j < 5 ? j : 0])) begin
                errors++; $display("FAIL gaps_done c=%0d: got %b", c, done);
            end
            if (j == 0 || j == 3 || j == 4) begin
                ref_div(pn[j], pd[j], eq, er, ez);
                checks++;
                if (Q !== eq || R !== er || div_by_zero !== ez) begin
                    errors++;
                    $display("FAIL gaps_result_%0d: got Q=%0d R=%0d expected Q=%0d R=%0d",
                             j, Q, R, eq, er);
                end
            end else if (j == 1 || j == 2) begin
                checks++;
                if (Q !== 16'd14 || R !== 8'd2) begin
                    errors++; $display("FAIL gaps_hold_%0d: got Q=%0d R=%0d expected Q=14 R=2", j, Q, R);
                end
            end
            start = (c < 5) ? pat[c] : 1'b0;
            N     = (c < 5) ? pn[c] : '0;
            D     = (c < 5) ? pd[c] : '0;
        end
        start = 1'b0;
    endtask

    // Products X*Y divided by Y must give back X.
    task automatic test_back_to_back();
        localparam int Len = 1000;
        logic [W-1:0]   xs [Len];
        logic [W-1:0]   ys [Len];
        logic [2*W-1:0] eq;
        int j;
        int seen = 0;
        for (int c = 0; c < Len + Lat + 2; c++) begin
            @(negedge clock);
            j = c - Lat;
            checks++;
            if (done !== (j >= 0 && j < Len)) begin
                errors++; $display("FAIL b2b_done c=%0d: got %b", c, done);
            end
            if (j >= 0 && j < Len) begin
                seen++;
                eq = (ys[j] != '0) ? {8'b0, xs[j]} : 16'hFFFF;
                checks++;
                if (Q !== eq || R !== '0 || div_by_zero !== (ys[j] == '0)) begin
                    errors++;
                    $display("FAIL b2b_%0d: X=%0d Y=%0d got Q=%0d R=%0d z=%b expected Q=%0d R=0",
                             j, xs[j], ys[j], Q, R, div_by_zero, eq);
                end
            end
            if (c < Len) begin
                xs[c] = W'($urandom);
                ys[c] = ($urandom_range(0, 31) == 0) ? '0 : W'($urandom);
                start = 1'b1;
                N     = xs[c] * ys[c];
                D     = ys[c];
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (seen != Len) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", seen, Len); end
    endtask

    task automatic test_random();
        localparam int Len = 300;
        logic           iv   [Len];
        logic [2*W-1:0] in_n [Len];
        logic [W-1:0]   in_d [Len];
        logic [2*W-1:0] eq, hq;
        logic [W-1:0]   er, hr;
        logic           ez, ev, have;
        int j;
        have = 1'b0;
        hq   = '0;
        hr   = '0;
        for (int c = 0; c < Len + Lat + 2; c++) begin
            @(negedge clock);
            j  = c - Lat;
            ev = (j >= 0 && j < Len) ? iv[j >= 0 && j < Len ? j : 0] : 1'b0;
            checks++;
            if (done !== ev) begin
                errors++; $display("FAIL rand_done c=%0d: got %b expected %b", c, done, ev);
            end
            if (ev) begin
                ref_div(in_n[j], in_d[j], eq, er, ez);
                checks++;
                if (Q !== eq || R !== er || div_by_zero !== ez) begin
                    errors++;
                    $display("FAIL rand_%0d: N=%0d D=%0d got Q=%0d R=%0d z=%b expected Q=%0d R=%0d z=%b",
                             j, in_n[j], in_d[j], Q, R, div_by_zero, eq, er, ez);
                end
                hq   = eq;
                hr   = er;
                have = 1'b1;
            end else if (have) begin
                checks++;
                if (Q !== hq || R !== hr) begin
                    errors++;
                    $display("FAIL rand_hold c=%0d: got Q=%0d R=%0d expected Q=%0d R=%0d", c, Q, R, hq, hr);
                end
            end
            if (c < Len) begin
                iv[c]   = ($urandom_range(0, 3) != 0);
                in_n[c] = 16'($urandom);
                in_d[c] = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
                start   = iv[c];
                N       = in_n[c];
                D       = in_d[c];
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_flight();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clock);
            checks++;
            if (done !== (c == Lat || c == 37)) begin
                errors++; $display("FAIL flush_done c=%0d: got %b", c, done);
            end
            if (c == Lat) begin
                checks++;
                if (Q !== 16'hFFFF || R !== 8'hAB || div_by_zero !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_pre: got Q=%0d R=%0d z=%b expected Q=65535 R=171 z=1",
                             Q, R, div_by_zero);
                end
                reset_n = 1'b0;
                #1;
                checks++;
                if (done !== 1'b0 || Q !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_async: got done=%b Q=%0d R=%0d z=%b expected all 0",
                             done, Q, R, div_by_zero);
                end
            end
            if (c == Lat + 1) reset_n = 1'b1;
            if (c == 37) begin
                checks++;
                if (Q !== 16'd142 || R !== 8'd6 || div_by_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_after: got Q=%0d R=%0d z=%b expected Q=142 R=6 z=0",
                             Q, R, div_by_zero);
                end
            end
            start = (c == 0) || (c >= 10 && c <= 14) || (c == 20);
            if (c == 0) begin
                N = 16'h12AB;
                D = 8'd0;
            end else if (c == 20) begin
                N = 16'd1000;
                D = 8'd7;
            end else begin
                N = 16'(c * 97);
                D = 8'(c);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_directed();
        test_gaps();
        test_back_to_back();
        test_random();
        test_reset_mid_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_divider.md
Name: array_divider

Overview:
- Fully pipelined restoring divider; the inverse of the team's pipelined array multiplier.
- Divides a 2*WIDTH-bit dividend (a product-sized operand) by a WIDTH-bit divisor, one quotient bit per stage.
- Accepts one operation per cycle and returns quotient, remainder and a divide-by-zero flag after a fixed latency.
- Sits beside the multiplier in the arithmetic microbenchmarks. Round-trip P/Y == X checks chain the two blocks.

Parameters:
WIDTH, 8, divisor/remainder width; dividend and quotient are 2*WIDTH bits; pipeline depth is 2*WIDTH stages.

Ports:
clock  input  1  single clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
N  input  2*WIDTH  dividend, sampled when start=1
D  input  WIDTH  divisor, sampled when start=1
start  input  1  operation valid this cycle; no ready, block always accepts
Q  output  2*WIDTH  quotient, valid when done=1
R  output  WIDTH  remainder, valid when done=1
div_by_zero  output  1  D was 0 for the operation completing this cycle, valid when done=1
done  output  1  one-cycle pulse per completed operation

Behaviour:
- Reset: reset_n low asynchronously clears every stage valid bit, done and div_by_zero. Q and R reset to 0. Datapath stage registers need no reset.
- Reset mid-operation: all in-flight operations are discarded; no done is emitted for them after release.
- Pipeline: 2*WIDTH register stages, each carrying valid, partial remainder (WIDTH+1 bits), unconsumed dividend bits, divisor, quotient-so-far and a zero flag.
- Stage s (0..2*WIDTH-1):
  - Form T = {partial_remainder[WIDTH-1:0], dividend bit (2*WIDTH-1-s)}.
  - If T >= {1'b0, divisor}: new remainder = T - divisor and quotient bit = 1.
  - Otherwise: new remainder = T and quotient bit = 0.
- Stage 0 starts with partial remainder 0.
- All compares and subtracts are unsigned, WIDTH+1 bits wide. The final remainder is always < D, so it fits in WIDTH bits.
- Latency: operands sampled with start=1 at rising edge k produce done=1 with Q/R/div_by_zero valid in the cycle after edge k+2*WIDTH. Q/R hold their value until the next completion.
- Throughput: one op per cycle. Consecutive starts give consecutive done pulses, in order. Gaps in start give identical gaps in done.
- Valid bits shift every cycle; there is no stall. done = valid bit of the last stage.
- Divide by zero: the datapath runs unmodified, which yields every quotient bit = 1. Q = all ones. R = N[WIDTH-1:0]. div_by_zero = 1.
- D != 0: div_by_zero = 0 and N == Q*D + R exactly.
- N=0: Q=0, R=0.
- D=1: Q=N, R=0.
- Q is a full 2*WIDTH bits, so no quotient overflow case exists.
- Pipeline registers are advanced even when their valid bit is 0 (no clock gating). Outputs change only on done.

Test Plan:
- W=8, single op N=1000, D=7 -> exactly 16 cycles later done=1, Q=142, R=6, div_by_zero=0; done low all other cycles.
- N=65535, D=255 -> Q=257, R=0. N=0, D=5 -> Q=0, R=0. N=40000, D=1 -> Q=40000, R=0.
- N=1234 (0x04D2), D=0 -> Q=0xFFFF, R=0xD2, div_by_zero=1. Next op N=10, D=3 -> Q=3, R=1, div_by_zero=0.
- 1000 back-to-back random ops (start held 1), products from the multiplier ROM divided by their Y operand -> 1000 consecutive done pulses in order. Each Q equals the X operand, R=0 when Y!=0.
- Start pattern 1,0,0,1,1 -> done pattern 1,0,0,1,1 sixteen cycles later; Q/R hold during gaps.
- Issue 5 ops, assert reset_n low for 1 cycle mid-flight -> done, div_by_zero, Q and R go to 0 immediately (asynchronously). No done from the flushed ops. A new op after release completes normally 16 cycles later.
